nvram_ioctl_bridge: RTL and testbench

Bridges the HPS ioctl file channel to the game's battery-backed CMOS RAM so high scores and operator settings survive power cycles. Download (HPS to core) restores a saved NVRAM image into the CMOS RAM; upload (core to HPS) reads the RAM back for saving. It sits beside `hps_io` on `clk_sys`. It owns the CMOS RAM's second port while a transfer is active, and flags the contents as dirty when the game writes CMOS.

---
 rtl/nvram_ioctl_bridge_if.sv | 27 ++
 rtl/nvram_ioctl_bridge.sv | 121 ++++++++++++
 tb/tb_nvram_ioctl_bridge.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/nvram_ioctl_bridge_if.sv
// HPS ioctl file channel as seen by the NVRAM bridge.
// master = hps_io side, slave = bridge side.
interface nvram_ioctl_bridge_if;
  logic        ioctl_download;
  logic        ioctl_upload;
  logic        ioctl_wr;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [15:0] ioctl_index;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;

  modport master (
    output ioctl_download, ioctl_upload,
    output ioctl_wr, ioctl_rd,
    output ioctl_addr, ioctl_dout, ioctl_index,
    input  ioctl_din, ioctl_wait
  );

  modport slave (
    input  ioctl_download, ioctl_upload,
    input  ioctl_wr, ioctl_rd,
    input  ioctl_addr, ioctl_dout, ioctl_index,
    output ioctl_din, ioctl_wait
  );
endinterface

// File: rtl/nvram_ioctl_bridge.sv
// Restores/saves the nibble-wide CMOS RAM over the HPS ioctl channel
// and tracks whether the game has changed it since the last transfer.
module nvram_ioctl_bridge #(
  parameter int          ADDR_W   = 10,
  parameter logic [15:0] NV_INDEX = 16'd4
) (
  input  logic              clk_sys,
  input  logic              reset,
  nvram_ioctl_bridge_if.slave io,
  output logic [ADDR_W-1:0] nv_addr,
  output logic [3:0]        nv_wdata,
  output logic              nv_we,
  input  logic [3:0]        nv_rdata,
  output logic              nv_busy,
  input  logic              core_cmos_we,
  output logic              nv_dirty
);

  typedef enum logic [2:0] {
    IDLE, DL_WR, UL_ADDR, UL_LAT, UL_OUT
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        wdata_q, wdata_d;
  logic [7:0]        din_q, din_d;
  logic              oor_q, oor_d;
  logic              busy_q;
  logic              dirty_q, dirty_d;
  logic              ul_q, ul_qq;
  logic              dl_q, dl_qq;

  logic sel, in_range, wr_go, rd_go;
  logic dirty_set, dirty_clr;

  assign sel      = (io.ioctl_index == NV_INDEX);
  assign in_range = ((io.ioctl_addr >> ADDR_W) == '0);
  assign wr_go    = io.ioctl_wr & sel & io.ioctl_download;
  assign rd_go    = io.ioctl_rd & sel & io.ioctl_upload;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    din_d   = din_q;
    oor_d   = oor_q;
    unique case (state_q)
      IDLE: begin
        if (wr_go) begin
          if (in_range) begin
            addr_d  = io.ioctl_addr[ADDR_W-1:0];
            wdata_d = io.ioctl_dout[3:0];
            state_d = DL_WR;
          end
        end else if (rd_go) begin
          addr_d  = io.ioctl_addr[ADDR_W-1:0];
          oor_d   = ~in_range;
          state_d = UL_ADDR;
        end
      end
      DL_WR:   state_d = IDLE;
      UL_ADDR: state_d = UL_LAT;
      UL_LAT: begin
        din_d   = oor_q ? 8'hFF : {4'hF, nv_rdata};
        state_d = UL_OUT;
      end
      UL_OUT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Clear acts on the registered fall, when nv_busy has already
  // dropped, so a core write in that same cycle still wins.
  assign dirty_set = core_cmos_we & ~busy_q;
  assign dirty_clr = (ul_qq & ~ul_q) | (dl_qq & ~dl_q);

  always_comb begin
    dirty_d = dirty_q;
    if (dirty_set)      dirty_d = 1'b1;
    else if (dirty_clr) dirty_d = 1'b0;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      din_q   <= 8'h00;
      oor_q   <= 1'b0;
      busy_q  <= 1'b0;
      dirty_q <= 1'b0;
      ul_q    <= 1'b0;
      ul_qq   <= 1'b0;
      dl_q    <= 1'b0;
      dl_qq   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      din_q   <= din_d;
      oor_q   <= oor_d;
      busy_q  <= sel & (io.ioctl_download | io.ioctl_upload);
      dirty_q <= dirty_d;
      ul_q    <= sel & io.ioctl_upload;
      ul_qq   <= ul_q;
      dl_q    <= sel & io.ioctl_download;
      dl_qq   <= dl_q;
    end
  end

  assign nv_addr       = addr_q;
  assign nv_wdata      = wdata_q;
  assign nv_we         = (state_q == DL_WR);
  assign nv_busy       = busy_q;
  assign nv_dirty      = dirty_q;
  assign io.ioctl_din  = din_q;
  assign io.ioctl_wait = (state_q == DL_WR) |
                         (state_q == UL_ADDR) |
                         (state_q == UL_LAT);

endmodule

// File: tb/tb_nvram_ioctl_bridge.sv
// Directed bench for nvram_ioctl_bridge with a registered CMOS RAM
// model and write/read scoreboards.
module tb_nvram_ioctl_bridge;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] nv_addr;
  logic [3:0] nv_wdata;
  logic       nv_we;
  logic [3:0] nv_rdata;
  logic       nv_busy;
  logic       core_cmos_we;
  logic       nv_dirty;

  nvram_ioctl_bridge_if io ();

  nvram_ioctl_bridge #(.ADDR_W(10), .NV_INDEX(16'd4)) dut (
    .clk_sys      (clk),
    .reset        (reset),
    .io           (io.slave),
    .nv_addr      (nv_addr),
    .nv_wdata     (nv_wdata),
    .nv_we        (nv_we),
    .nv_rdata     (nv_rdata),
    .nv_busy      (nv_busy),
    .core_cmos_we (core_cmos_we),
    .nv_dirty     (nv_dirty)
  );

  always #5 clk = ~clk;

  logic [3:0] mem [1024];
  always @(posedge clk) begin
    if (nv_we) mem[nv_addr] <= nv_wdata;
    nv_rdata <= mem[nv_addr];
  end

  int passed = 0;
  int total  = 0;
  int fails  = 0;
  logic [13:0] wq [$];
  logic [7:0]  rq [$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (nv_we === 1'b1) begin
      if (wq.size() == 0) chk("unexpected_we", 1, 0);
      else chk("we_addr_data", {18'd0, nv_addr, nv_wdata}, {18'd0, wq.pop_front()});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dl_byte(input logic [24:0] a, input logic [7:0] d,
                         input bit expect_wr);
    if (expect_wr) wq.push_back({a[9:0], d[3:0]});
    io.ioctl_wr = 1'b1;
    io.ioctl_addr = a;
    io.ioctl_dout = d;
    step();
    io.ioctl_wr = 1'b0;
    chk("dl_we_c1", nv_we, expect_wr);
    chk("dl_wait_c1", io.ioctl_wait, expect_wr);
    step();
    chk("dl_we_c2", nv_we, 0);
    chk("dl_wait_c2", io.ioctl_wait, 0);
  endtask

  task automatic ul_byte(input logic [24:0] a, input logic [7:0] exp);
    rq.push_back(exp);
    io.ioctl_rd = 1'b1;
    io.ioctl_addr = a;
    step();
    io.ioctl_rd = 1'b0;
    chk("ul_wait_c1", io.ioctl_wait, 1);
    chk("ul_addr_c1", nv_addr, a[9:0]);
    step();
    chk("ul_wait_c2", io.ioctl_wait, 1);
    step();
    chk("ul_wait_c3", io.ioctl_wait, 0);
    chk("ul_din_c3", io.ioctl_din, rq.pop_front());
    step();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 4'h0;
    mem[7] = 4'h9;
    reset = 1'b1;
    core_cmos_we = 1'b0;
    io.ioctl_download = 1'b0;
    io.ioctl_upload = 1'b0;
    io.ioctl_wr = 1'b0;
    io.ioctl_rd = 1'b0;
    io.ioctl_addr = '0;
    io.ioctl_dout = '0;
    io.ioctl_index = 16'd4;
    step(); step(); step();
    chk("rst_wait", io.ioctl_wait, 0);
    chk("rst_we", nv_we, 0);
    chk("rst_addr", nv_addr, 0);
    chk("rst_wdata", nv_wdata, 0);
    chk("rst_din", io.ioctl_din, 8'h00);
    chk("rst_busy", nv_busy, 0);
    chk("rst_dirty", nv_dirty, 0);
    reset = 1'b0;
    step();

    io.ioctl_download = 1'b1;
    step();
    chk("busy_dl", nv_busy, 1);
    dl_byte(25'd0, 8'hA5, 1'b1);
    dl_byte(25'd1023, 8'h3C, 1'b1);
    core_cmos_we = 1'b1;
    step();
    core_cmos_we = 1'b0;
    chk("dirty_busy_blocked", nv_dirty, 0);
    io.ioctl_download = 1'b0;
    step(); step();
    chk("mem0", mem[0], 4'h5);
    chk("mem1023", mem[1023], 4'hC);

    io.ioctl_index = 16'd0;
    io.ioctl_download = 1'b1;
    step();
    chk("busy_nosel", nv_busy, 0);
    dl_byte(25'd5, 8'h77, 1'b0);
    io.ioctl_download = 1'b0;
    io.ioctl_index = 16'd4;
    step();
    io.ioctl_download = 1'b1;
    step();
    dl_byte(25'd1024, 8'h7E, 1'b0);
    io.ioctl_download = 1'b0;
    step(); step(); step();
    chk("mem5_kept", mem[5], 4'h0);
    chk("mem0_kept", mem[0], 4'h5);

    core_cmos_we = 1'b1;
    step();
    core_cmos_we = 1'b0;
    chk("dirty_set", nv_dirty, 1);

    io.ioctl_upload = 1'b1;
    step(); step();
    ul_byte(25'd7, 8'hF9);
    ul_byte(25'd2000, 8'hFF);
    io.ioctl_upload = 1'b0;
    step();
    step();
    chk("dirty_cleared", nv_dirty, 0);

    step();
    core_cmos_we = 1'b1;
    step();
    core_cmos_we = 1'b0;
    chk("dirty_set2", nv_dirty, 1);
    io.ioctl_upload = 1'b1;
    step(); step();
    ul_byte(25'd0, 8'hF5);
    io.ioctl_upload = 1'b0;
    step();
    core_cmos_we = 1'b1;
    step();
    core_cmos_we = 1'b0;
    chk("dirty_set_wins", nv_dirty, 1);
    step();
    chk("dirty_set_wins_hold", nv_dirty, 1);

    io.ioctl_upload = 1'b1;
    step(); step();
    io.ioctl_rd = 1'b1;
    io.ioctl_addr = 25'd7;
    step();
    io.ioctl_rd = 1'b0;
    step();
    chk("pre_rst_wait", io.ioctl_wait, 1);
    reset = 1'b1;
    step();
    chk("rst_mid_wait", io.ioctl_wait, 0);
    chk("rst_mid_din", io.ioctl_din, 8'h00);
    chk("rst_mid_busy", nv_busy, 0);
    reset = 1'b0;
    step(); step();
    ul_byte(25'd1023, 8'hFC);
    step(); step();
    chk("din_hold", io.ioctl_din, 8'hFC);
    io.ioctl_upload = 1'b0;
    step(); step();
    chk("wq_drained", wq.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
